// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types: the machine word and the memory-stage controller states.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;
    // Word-address width: byte address with the two byte-offset bits dropped.
    localparam int WADDR_W = WORD_W - 2;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [WADDR_W-1:0] waddr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } memstate_t;

endpackage

// File: rtl/mem_access_ctrl_ll_link_reg.sv
// -----------------------------------------------------------------------------
// ll_link_reg
// Per-core LL/SC link register. Holds the linked word address and its valid
// bit, applies set/clear events from completed accesses and snoop invalidates,
// and reports whether an SC to a given word would currently succeed.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   set_i             LL completed this cycle (link acc_waddr_i)
//   sc_done_i         SC completed this cycle (consume the link)
//   st_done_i         plain store completed this cycle at acc_waddr_i
//   acc_waddr_i       word address of the completing access
//   snoop_inv_i       remote invalidate this cycle
//   snoop_waddr_i     word address of the remote invalidate
//   chk_waddr_i       word address of the SC being evaluated
//   sc_ok_o           link valid, matches chk_waddr_i, and no same-cycle
//                     matching snoop
// -----------------------------------------------------------------------------
module ll_link_reg
    import cpu_types_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   set_i,
    input  logic   sc_done_i,
    input  logic   st_done_i,
    input  waddr_t acc_waddr_i,
    input  logic   snoop_inv_i,
    input  waddr_t snoop_waddr_i,
    input  waddr_t chk_waddr_i,
    output logic   sc_ok_o
);

    logic   link_valid_q, link_valid_d;
    waddr_t link_addr_q,  link_addr_d;

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (set_i) begin
            link_valid_d = 1'b1;
            link_addr_d  = acc_waddr_i;
        end
        if (sc_done_i) begin
            link_valid_d = 1'b0;
        end
        if (st_done_i && (acc_waddr_i == link_addr_q)) begin
            link_valid_d = 1'b0;
        end
        // Compare against the next address so a snoop that lands on the very
        // cycle an LL completes still kills the fresh link.
        if (snoop_inv_i && (snoop_waddr_i == link_addr_d)) begin
            link_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign sc_ok_o = link_valid_q
                  && (chk_waddr_i == link_addr_q)
                  && !(snoop_inv_i && (snoop_waddr_i == link_addr_q));

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage access controller. Turns the EX/MEM memory controls into a
// held request/hit handshake with the data cache, returns load data (or the
// SC result) and a combinational stall, and owns the LL/SC link register.
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   DRen_i, DWen_i              load / store request from EX/MEM
//   ll_i, sc_i                  load is LL / store is SC
//   halt_i                      halt reached the memory stage
//   aluout_i, rdat2_i           effective address / store data
//   dhit, dmemload              cache completion and read data
//   snoop_inv, snoop_addr       remote invalidate and its address
//   dmemREN, dmemWEN            registered cache read / write request
//   dmemaddr, dmemstore         registered cache address / write data
//   mem_stall                   combinational freeze of IF..EX/MEM
//   load_o                      captured load data or SC result (0/1)
//   halt_o                      sticky halt to the flush logic
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  DRen_i,
    input  logic  DWen_i,
    input  logic  ll_i,
    input  logic  sc_i,
    input  logic  halt_i,
    input  word_t aluout_i,
    input  word_t rdat2_i,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_stall,
    output word_t load_o,
    output logic  halt_o
);

    memstate_t state_q;
    logic      dmem_ren_q, dmem_wen_q;
    word_t     dmem_addr_q, dmem_store_q;
    word_t     load_q;
    logic      halt_q;
    logic      ll_q, sc_q;

    logic      req_any;
    logic      req_is_sc;
    logic      sc_ok;
    logic      acc_hit;
    logic      unused_snoop_offset;

    // Byte offset of a snoop is irrelevant: link granularity is one word.
    assign unused_snoop_offset = ^snoop_addr[1:0];

    assign req_any   = DRen_i | DWen_i;
    // Read wins on a (malformed) simultaneous request, so SC only counts
    // when it is really a write.
    assign req_is_sc = sc_i & DWen_i & ~DRen_i;
    assign acc_hit   = (state_q == ACCESS) & dhit;

    ll_link_reg u_link (
        .CLK           (CLK),
        .RST           (RST),
        .set_i         (acc_hit & dmem_ren_q & ll_q),
        .sc_done_i     (acc_hit & dmem_wen_q & sc_q),
        .st_done_i     (acc_hit & dmem_wen_q & ~sc_q),
        .acc_waddr_i   (dmem_addr_q[31:2]),
        .snoop_inv_i   (snoop_inv),
        .snoop_waddr_i (snoop_addr[31:2]),
        .chk_waddr_i   (aluout_i[31:2]),
        .sc_ok_o       (sc_ok)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            dmem_ren_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_store_q <= '0;
            load_q       <= '0;
            halt_q       <= 1'b0;
            ll_q         <= 1'b0;
            sc_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        if (req_is_sc && !sc_ok) begin
                            // Failed SC never reaches the cache.
                            state_q <= DONE;
                            load_q  <= '0;
                        end else begin
                            state_q      <= ACCESS;
                            dmem_ren_q   <= DRen_i;
                            dmem_wen_q   <= DWen_i & ~DRen_i;
                            dmem_addr_q  <= aluout_i;
                            dmem_store_q <= rdat2_i;
                            ll_q         <= DRen_i & ll_i;
                            sc_q         <= req_is_sc;
                        end
                    end else if (halt_i) begin
                        state_q <= HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        state_q    <= DONE;
                        dmem_ren_q <= 1'b0;
                        dmem_wen_q <= 1'b0;
                        if (dmem_ren_q) begin
                            load_q <= dmemload;
                        end else if (sc_q) begin
                            load_q <= 32'd1;
                        end
                    end
                end
                DONE: begin
                    // One unstalled cycle lets EX/MEM advance before the
                    // next request is looked at.
                    state_q <= IDLE;
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            IDLE:    mem_stall = req_any;
            ACCESS:  mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    assign dmemREN   = dmem_ren_q;
    assign dmemWEN   = dmem_wen_q;
    assign dmemaddr  = dmem_addr_q;
    assign dmemstore = dmem_store_q;
    assign load_o    = load_q;
    assign halt_o    = halt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DRen_i, DWen_i, ll_i, sc_i, halt_i;
    logic [31:0] aluout_i, rdat2_i;
    logic        dhit;
    logic [31:0] dmemload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        mem_stall;
    logic [31:0] load_o;
    logic        halt_o;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_access_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .DRen_i     (DRen_i),
        .DWen_i     (DWen_i),
        .ll_i       (ll_i),
        .sc_i       (sc_i),
        .halt_i     (halt_i),
        .aluout_i   (aluout_i),
        .rdat2_i    (rdat2_i),
        .dhit       (dhit),
        .dmemload   (dmemload),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .mem_stall  (mem_stall),
        .load_o     (load_o),
        .halt_o     (halt_o)
    );

    typedef struct {
        string       name;
        logic        ren, wen, ll, sc;
        logic [31:0] addr, wdata, rdata;
        int          miss;         // extra ACCESS cycles before dhit
        logic        snoop;        // snoop in the IDLE cycle of the request
        logic [31:0] snoop_addr;
        int          exp_stall;
        int          exp_ren;
        int          exp_wen;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        DRen_i = 0; DWen_i = 0; ll_i = 0; sc_i = 0; halt_i = 0;
        aluout_i = 0; rdat2_i = 0; dhit = 0; dmemload = 0;
        snoop_inv = 0; snoop_addr = 0;
    endtask

    // Drive one memory op and act as the cache; inputs are held while the
    // stall is up, as the frozen EX/MEM latch would.
    task automatic run_vec(input vec_t v);
        int stall_cnt = 0, ren_cnt = 0, wen_cnt = 0, acc = 0;
        logic done = 0;
        logic [31:0] cap_addr = 0, cap_store = 0;
        @(negedge CLK);
        DRen_i = v.ren; DWen_i = v.wen; ll_i = v.ll; sc_i = v.sc;
        aluout_i = v.addr; rdat2_i = v.wdata; dmemload = v.rdata;
        snoop_inv = v.snoop; snoop_addr = v.snoop_addr; dhit = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (dmemREN || dmemWEN) begin
                if (acc == 0) begin cap_addr = dmemaddr; cap_store = dmemstore; end
                acc++;
                if (dmemREN) ren_cnt++;
                if (dmemWEN) wen_cnt++;
                dhit = (acc > v.miss);
            end else begin
                dhit = 0;
            end
            #1;
            if (mem_stall) stall_cnt++;
            else done = 1;
            if (!done) begin
                @(negedge CLK);
                snoop_inv = 0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: stall never dropped, expected %0d stall cycles", v.name, v.exp_stall);
        end
        check({v.name, " stall_cycles"}, stall_cnt, v.exp_stall);
        check({v.name, " ren_cycles"}, ren_cnt, v.exp_ren);
        check({v.name, " wen_cycles"}, wen_cnt, v.exp_wen);
        check({v.name, " load_o"}, load_o, v.exp_load);
        check({v.name, " no_req_in_done"}, {30'd0, dmemREN, dmemWEN}, 32'd0);
        if (v.exp_ren + v.exp_wen > 0) check({v.name, " dmemaddr"}, cap_addr, v.addr);
        if (v.exp_wen > 0) check({v.name, " dmemstore"}, cap_store, v.wdata);
        $display("txn %-12s addr=0x%08h stall=%0d ren=%0d wen=%0d load=0x%08h", v.name, v.addr,
                 stall_cnt, ren_cnt, wen_cnt, load_o);
        @(negedge CLK);
        clear_inputs();
    endtask

    function automatic vec_t mk(string n, logic r, logic w, logic l, logic s, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd, int m, logic sn,
                                logic [31:0] sa, int es, int er, int ew, logic [31:0] el);
        vec_t v;
        v.name = n; v.ren = r; v.wen = w; v.ll = l; v.sc = s; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.miss = m; v.snoop = sn; v.snoop_addr = sa; v.exp_stall = es;
        v.exp_ren = er; v.exp_wen = ew; v.exp_load = el;
        return v;
    endfunction

    initial begin
        //          name          r  w  ll sc addr      wdata         rdata         m  sn saddr     st rn wn load
        vecs.push_back(mk("lw_miss3",  1, 0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 0, 32'h0,   4, 3, 0, 32'hDEADBEEF));
        vecs.push_back(mk("sw_hit",    0, 1, 0, 0, 32'h200, 32'h12345678, 32'h0,        0, 0, 32'h0,   2, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk("ll_300",    1, 0, 1, 0, 32'h300, 32'h0,        32'hCAFEF00D, 0, 0, 32'h0,   2, 1, 0, 32'hCAFEF00D));
        vecs.push_back(mk("sc_300_ok", 0, 1, 0, 1, 32'h300, 32'h5,        32'h0,        0, 0, 32'h0,   2, 0, 1, 32'd1));
        vecs.push_back(mk("sc_300_2nd",0, 1, 0, 1, 32'h300, 32'h6,        32'h0,        0, 0, 32'h0,   1, 0, 0, 32'd0));
        vecs.push_back(mk("ll_300_m1", 1, 0, 1, 0, 32'h300, 32'h0,        32'h11,       1, 0, 32'h0,   3, 2, 0, 32'h11));
        vecs.push_back(mk("sc_snoop",  0, 1, 0, 1, 32'h300, 32'h7,        32'h0,        0, 1, 32'h302, 1, 0, 0, 32'd0));
        vecs.push_back(mk("ll_400",    1, 0, 1, 0, 32'h400, 32'h0,        32'h22,       0, 0, 32'h0,   2, 1, 0, 32'h22));
        vecs.push_back(mk("sw_404",    0, 1, 0, 0, 32'h404, 32'h99,       32'h0,        0, 0, 32'h0,   2, 0, 1, 32'h22));
        vecs.push_back(mk("sc_402_ok", 0, 1, 0, 1, 32'h402, 32'h8,        32'h0,        1, 0, 32'h0,   3, 0, 2, 32'd1));
        vecs.push_back(mk("ll_500",    1, 0, 1, 0, 32'h500, 32'h0,        32'h33,       0, 0, 32'h0,   2, 1, 0, 32'h33));
        vecs.push_back(mk("sw_500",    0, 1, 0, 0, 32'h500, 32'hAA,       32'h0,        0, 0, 32'h0,   2, 0, 1, 32'h33));
        vecs.push_back(mk("sc_500_bad",0, 1, 0, 1, 32'h500, 32'h9,        32'h0,        0, 0, 32'h0,   1, 0, 0, 32'd0));
        vecs.push_back(mk("rw_both",   1, 1, 0, 0, 32'h600, 32'hBB,       32'h44,       0, 0, 32'h0,   2, 1, 0, 32'h44));
        vecs.push_back(mk("sc_nolink", 0, 1, 0, 1, 32'h700, 32'h1,        32'h0,        0, 0, 32'h0,   1, 0, 0, 32'd0));
        vecs.push_back(mk("ll_800",    1, 0, 1, 0, 32'h800, 32'h0,        32'h55,       0, 0, 32'h0,   2, 1, 0, 32'h55));
        vecs.push_back(mk("lw_snp800", 1, 0, 0, 0, 32'h900, 32'h0,        32'h66,       1, 1, 32'h801, 3, 2, 0, 32'h66));
        vecs.push_back(mk("sc_800_bad",0, 1, 0, 1, 32'h800, 32'h2,        32'h0,        0, 0, 32'h0,   1, 0, 0, 32'd0));

        clear_inputs();
        RST = 1;
        repeat (3) @(negedge CLK);
        RST = 0;
        #1;
        check("reset dmemREN", {31'd0, dmemREN}, 32'd0);
        check("reset dmemWEN", {31'd0, dmemWEN}, 32'd0);
        check("reset dmemaddr", dmemaddr, 32'd0);
        check("reset dmemstore", dmemstore, 32'd0);
        check("reset load_o", load_o, 32'd0);
        check("reset halt_o", {31'd0, halt_o}, 32'd0);
        check("reset mem_stall", {31'd0, mem_stall}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during the second ACCESS cycle of a load that never hits.
        @(negedge CLK);
        DRen_i = 1; aluout_i = 32'h100;
        @(negedge CLK); #1;
        check("rst_mid first ACCESS dmemREN", {31'd0, dmemREN}, 32'd1);
        @(negedge CLK); #1;
        check("rst_mid second ACCESS dmemREN", {31'd0, dmemREN}, 32'd1);
        RST = 1; DRen_i = 0; aluout_i = 0;
        @(negedge CLK); #1;
        RST = 0;
        check("rst_mid dmemREN", {31'd0, dmemREN}, 32'd0);
        check("rst_mid dmemWEN", {31'd0, dmemWEN}, 32'd0);
        check("rst_mid dmemaddr", dmemaddr, 32'd0);
        check("rst_mid load_o", load_o, 32'd0);
        check("rst_mid mem_stall", {31'd0, mem_stall}, 32'd0);
        $display("txn rst_mid      reset applied in second ACCESS cycle");
        // Back in IDLE: a minimal load takes exactly two stall cycles.
        run_vec(mk("lw_after_rst", 1, 0, 0, 0, 32'h104, 32'h0, 32'h77, 0, 0, 32'h0, 2, 1, 0, 32'h77));
        // Link was cleared by reset: SC to the old link fails.
        run_vec(mk("ll_a00",     1, 0, 1, 0, 32'hA00, 32'h0, 32'h88, 0, 0, 32'h0, 2, 1, 0, 32'h88));
        @(negedge CLK);
        RST = 1;
        @(negedge CLK);
        RST = 0;
        run_vec(mk("sc_a00_rst", 0, 1, 0, 1, 32'hA00, 32'h3, 32'h0, 0, 0, 32'h0, 1, 0, 0, 32'd0));

        // Halt with no request, then a load that must be ignored.
        @(negedge CLK);
        halt_i = 1;
        #1;
        check("halt same cycle halt_o", {31'd0, halt_o}, 32'd0);
        @(negedge CLK);
        halt_i = 0;
        #1;
        check("halt next cycle halt_o", {31'd0, halt_o}, 32'd1);
        DRen_i = 1; aluout_i = 32'h100;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1;
            check("halted dmemREN", {31'd0, dmemREN}, 32'd0);
            check("halted mem_stall", {31'd0, mem_stall}, 32'd0);
            check("halted halt_o", {31'd0, halt_o}, 32'd1);
        end
        $display("txn halt         halt_o=%0b dmemREN=%0b", halt_o, dmemREN);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
